// File: rtl/rg_wb_arbiter_pkg.sv
// rtl/rg_wb_arbiter_pkg.sv - shared widths for the register-file writeback arbiter
package rg_wb_arbiter_pkg;
  localparam int REG_LENGTH_IN_INST = 5;
  localparam int INST_BUS_LENGTH    = 32;
  localparam int REG_NUMBER         = 32;
endpackage

// File: rtl/rg_wb_arbiter_if.sv
// rtl/rg_wb_arbiter_if.sv - valid/ready writeback request channel (one per source)
interface rg_wb_arbiter_if
  import rg_wb_arbiter_pkg::*;
#(
  parameter int ADDR_W = REG_LENGTH_IN_INST,
  parameter int DATA_W = INST_BUS_LENGTH
);
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] dst;
  logic [DATA_W-1:0] data;

  modport master (output valid, dst, data, input ready);
  modport slave  (input valid, dst, data, output ready);
endinterface

// File: rtl/rg_wb_arbiter_rr_arb2.sv
// rtl/rg_wb_arbiter_rr_arb2.sv - 2-way arbiter; round-robin, or B-priority with RG_WB_FIXED_PRIO_EN
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);
`ifdef RG_WB_FIXED_PRIO_EN
  always_comb begin
    gnt_o = 2'b00;
    if (req_i[1])      gnt_o = 2'b10;
    else if (req_i[0]) gnt_o = 2'b01;
  end
`else
  // prio_b_q=1 means B wins the next tie; reset favours A
  logic prio_b_q, prio_b_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) prio_b_q <= 1'b0;
    else          prio_b_q <= prio_b_d;
  end

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) gnt_o = prio_b_q ? 2'b10 : 2'b01;
  end

  always_comb begin
    prio_b_d = prio_b_q;
    if (|gnt_o) prio_b_d = gnt_o[0];
  end
`endif
endmodule

// File: rtl/rg_wb_arbiter.sv
// rtl/rg_wb_arbiter.sv - register-file write-port arbiter with pending-write scoreboard
// Optional: RG_WB_FIXED_PRIO_EN selects fixed B priority in rr_arb2.
module rg_wb_arbiter
  import rg_wb_arbiter_pkg::*;
#(
  parameter int ADDR_W = REG_LENGTH_IN_INST,
  parameter int DATA_W = INST_BUS_LENGTH,
  parameter int NREG   = REG_NUMBER
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  rg_wb_arbiter_if.slave    a_if,
  rg_wb_arbiter_if.slave    b_if,
  input  logic              mark_i,
  input  logic [ADDR_W-1:0] mark_reg_i,
  input  logic [ADDR_W-1:0] q1_reg_i,
  input  logic [ADDR_W-1:0] q2_reg_i,
  output logic              busy1_o,
  output logic              busy2_o,
  output logic              regWrite_o,
  output logic [ADDR_W-1:0] reg3_o,
  output logic [DATA_W-1:0] data3_o
);
  if (NREG != 2**ADDR_W) begin : g_bad_nreg
    $error("NREG must equal 2**ADDR_W");
  end

  logic [1:0]        gnt;
  logic [ADDR_W-1:0] win_reg;
  logic [DATA_W-1:0] win_data;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] reg3_q, reg3_d;
  logic [DATA_W-1:0] data3_q, data3_d;
  logic [NREG-1:0]   busy_q, busy_d;

  rr_arb2 u_arb (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .req_i   ({b_if.valid, a_if.valid}),
    .gnt_o   (gnt)
  );

  assign a_if.ready = gnt[0];
  assign b_if.ready = gnt[1];
  assign win_reg    = gnt[1] ? b_if.dst  : a_if.dst;
  assign win_data   = gnt[1] ? b_if.data : a_if.data;

  // Writes to reg 0 are consumed but never reach the register file
  always_comb begin
    we_d    = (|gnt) && (win_reg != '0);
    reg3_d  = we_d ? win_reg  : reg3_q;
    data3_d = we_d ? win_data : data3_q;
  end

  // Clear first so a same-cycle mark of the same register wins
  always_comb begin
    busy_d = busy_q;
    if (gnt[1]) busy_d[b_if.dst] = 1'b0;
    if (mark_i && (mark_reg_i != '0)) busy_d[mark_reg_i] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      we_q    <= 1'b0;
      reg3_q  <= '0;
      data3_q <= '0;
      busy_q  <= '0;
    end else begin
      we_q    <= we_d;
      reg3_q  <= reg3_d;
      data3_q <= data3_d;
      busy_q  <= busy_d;
    end
  end

  assign regWrite_o = we_q;
  assign reg3_o     = reg3_q;
  assign data3_o    = data3_q;
  assign busy1_o    = busy_q[q1_reg_i];
  assign busy2_o    = busy_q[q2_reg_i];
endmodule

// File: tb/tb_rg_wb_arbiter.sv
// tb/tb_rg_wb_arbiter.sv - directed table-driven bench for rg_wb_arbiter
module tb_rg_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        mark;
  logic [4:0]  mark_reg, q1, q2;
  logic        busy1, busy2, we;
  logic [4:0]  reg3;
  logic [31:0] data3;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] tb_busy;

`ifdef RG_WB_FIXED_PRIO_EN
  localparam bit FIX = 1'b1;
`else
  localparam bit FIX = 1'b0;
`endif

  always #5 clk = ~clk;

  rg_wb_arbiter_if a_if ();
  rg_wb_arbiter_if b_if ();

  rg_wb_arbiter dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .a_if       (a_if.slave),
    .b_if       (b_if.slave),
    .mark_i     (mark),
    .mark_reg_i (mark_reg),
    .q1_reg_i   (q1),
    .q2_reg_i   (q2),
    .busy1_o    (busy1),
    .busy2_o    (busy2),
    .regWrite_o (we),
    .reg3_o     (reg3),
    .data3_o    (data3)
  );

  // Marking a register that already has a pending write is illegal stimulus
  always @(posedge clk) begin
    if (rst_n && mark && mark_reg != 5'd0)
      assert (!tb_busy[mark_reg]) else $error("illegal mark of busy reg %0d", mark_reg);
    if (!rst_n) tb_busy <= '0;
    else begin
      if (b_if.valid && b_if.ready) tb_busy[b_if.dst] <= 1'b0;
      if (mark && mark_reg != 5'd0) tb_busy[mark_reg] <= 1'b1;
    end
  end

  typedef struct {
    logic av; logic [4:0] ar; logic [31:0] ad;
    logic bv; logic [4:0] br; logic [31:0] bd;
    logic mk; logic [4:0] mr; logic [4:0] q1; logic [4:0] q2;
    logic ea; logic eb; logic e1; logic e2; logic ew;
    logic chk; logic [4:0] er; logic [31:0] ed;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t v(logic av, logic [4:0] ar, logic [31:0] ad,
                             logic bv, logic [4:0] br, logic [31:0] bd,
                             logic mk, logic [4:0] mr, logic [4:0] q1_, logic [4:0] q2_,
                             logic ea, logic eb, logic e1, logic e2, logic ew,
                             logic chk, logic [4:0] er, logic [31:0] ed);
    vec_t r;
    r.av = av; r.ar = ar; r.ad = ad; r.bv = bv; r.br = br; r.bd = bd;
    r.mk = mk; r.mr = mr; r.q1 = q1_; r.q2 = q2_;
    r.ea = ea; r.eb = eb; r.e1 = e1; r.e2 = e2; r.ew = ew;
    r.chk = chk; r.er = er; r.ed = ed;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    a_if.valid = t.av; a_if.dst = t.ar; a_if.data = t.ad;
    b_if.valid = t.bv; b_if.dst = t.br; b_if.data = t.bd;
    mark = t.mk; mark_reg = t.mr; q1 = t.q1; q2 = t.q2;
  endtask

  initial begin
    vec_t idle;
    idle = v(0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0,0);
    drive(idle);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", we, 0); chk("rst_reg3", reg3, 0); chk("rst_data3", data3, 0);
    chk("rst_a_ready", a_if.ready, 0); chk("rst_busy1", busy1, 0);
    @(negedge clk) rst_n = 1'b1;

    // Reset mid-write: busy reg 12 and a registered A write both vanish
    @(negedge clk); mark = 1'b1; mark_reg = 5'd12;
    @(negedge clk); mark = 1'b0;
    a_if.valid = 1'b1; a_if.dst = 5'd5; a_if.data = 32'h11; q1 = 5'd12;
    #1;
    chk("mid_a_ready", a_if.ready, 1); chk("mid_busy1", busy1, 1);
    @(posedge clk); #1;
    chk("mid_we", we, 1); chk("mid_reg3", reg3, 5); chk("mid_data3", data3, 32'h11);
    a_if.valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", we, 0); chk("mid_rst_reg3", reg3, 0);
    chk("mid_rst_data3", data3, 0); chk("mid_rst_busy1", busy1, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_we", we, 0);

    tbl[0]  = v(1,3,32'hDEADBEEF, 0,0,0, 0,0,0,0, 1,0,0,0,1, 1,3,32'hDEADBEEF);
    tbl[1]  = v(0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0, 1,3,32'hDEADBEEF);
    tbl[2]  = v(0,0,0, 1,4,32'h44, 0,0,0,0, 0,1,0,0,1, 1,4,32'h44);
    for (int k = 0; k < 4; k++) begin
      logic aw;
      aw = !FIX && (k % 2 == 0);
      tbl[3+k] = v(1,1,32'hA1, 1,2,32'hB2, 0,0,0,0, aw,!aw,0,0,1, 1,
                   aw ? 5'd1 : 5'd2, aw ? 32'hA1 : 32'hB2);
    end
    tbl[7]  = v(0,0,0, 0,0,0, 1,7,7,0, 0,0,0,0,0, 1,2,32'hB2);
    tbl[8]  = v(1,8,32'h88, 0,0,0, 0,0,7,0, 1,0,1,0,1, 1,8,32'h88);
    tbl[9]  = v(0,0,0, 1,7,32'h77, 0,0,7,0, 0,1,1,0,1, 1,7,32'h77);
    tbl[10] = v(0,0,0, 0,0,0, 0,0,7,0, 0,0,0,0,0, 1,7,32'h77);
    tbl[11] = v(1,0,32'h55, 0,0,0, 0,0,0,0, 1,0,0,0,0, 0,0,0);
    tbl[12] = v(0,0,0, 0,0,0, 1,0,0,0, 0,0,0,0,0, 0,0,0);
    tbl[13] = v(0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0,0);
    tbl[14] = v(0,0,0, 1,9,32'h99, 1,9,0,9, 0,1,0,0,1, 1,9,32'h99);
    tbl[15] = v(0,0,0, 0,0,0, 0,0,7,9, 0,0,0,1,0, 1,9,32'h99);
    tbl[16] = v(0,0,0, 1,9,32'h9A, 0,0,0,9, 0,1,0,1,1, 1,9,32'h9A);
    tbl[17] = v(0,0,0, 0,0,0, 0,0,0,9, 0,0,0,0,0, 1,9,32'h9A);

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d_a_ready", i), a_if.ready, tbl[i].ea);
      chk($sformatf("v%0d_b_ready", i), b_if.ready, tbl[i].eb);
      chk($sformatf("v%0d_busy1", i), busy1, tbl[i].e1);
      chk($sformatf("v%0d_busy2", i), busy2, tbl[i].e2);
      @(posedge clk); #1;
      chk($sformatf("v%0d_we", i), we, tbl[i].ew);
      if (tbl[i].chk) begin
        chk($sformatf("v%0d_reg3", i), reg3, tbl[i].er);
        chk($sformatf("v%0d_data3", i), data3, tbl[i].ed);
      end
    end

    @(negedge clk);
    drive(idle);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
